sin_phase_feed: RTL

Upstream stage of the sine evaluator. Holds a 32-bit phase accumulator (one full turn = 2^32) and advances it on each sample tick. Folds each phase sample into [-pi/2, +pi/2] and converts it to an IEEE-754 single-precision theta. Emits a one-cycle start pulse that, with theta, drives the sine unit's reset/theta inputs.

---
 rtl/sin_phase_feed_pkg.sv | 28 ++
 rtl/sin_phase_feed_ufix62_to_fp32.sv | 40 ++++
 rtl/sin_phase_feed.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/sin_phase_feed_pkg.sv
// ----------------------------------------------------------------------------
// sin_pkg
//   Shared constants and types for the sine-evaluator front end.
//   - PI_Q30    : round(pi * 2^30), the scale that maps a folded phase onto
//                 radians.
//   - FP32_BIAS : IEEE-754 single-precision exponent bias.
//   - state_t   : phase-feed FSM encoding.
//   - fp32_exp_from_msb : biased exponent for an unsigned Q1.61 magnitude
//                 whose most significant set bit sits at index msb.
// ----------------------------------------------------------------------------
package sin_pkg;

    localparam logic [31:0] PI_Q30    = 32'hC90FDAA2;
    localparam logic [7:0]  FP32_BIAS = 8'd127;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FOLD = 2'd1,
        ST_MULT = 2'd2,
        ST_PACK = 2'd3
    } state_t;

    // The magnitude carries 61 fraction bits, so bit msb has weight 2^(msb-61).
    function automatic logic [7:0] fp32_exp_from_msb(input logic [5:0] msb);
        return {2'b00, msb} + FP32_BIAS - 8'd61;
    endfunction

endpackage

// File: rtl/sin_phase_feed_ufix62_to_fp32.sv
// ----------------------------------------------------------------------------
// ufix62_to_fp32
//   Combinational conversion of a sign plus an unsigned 62-bit Q1.61
//   magnitude into IEEE-754 single precision. The mantissa is truncated
//   (round toward zero). A zero magnitude always yields +0.
//   Ports:
//     i_sign  - sign of the value (1 = negative)
//     i_mag   - unsigned magnitude, value = i_mag * 2^-61
//     o_fp32  - packed single-precision result
// ----------------------------------------------------------------------------
module ufix62_to_fp32
    import sin_pkg::*;
(
    input  logic        i_sign,
    input  logic [61:0] i_mag,
    output logic [31:0] o_fp32
);

    logic [5:0]  w_msb;
    logic [61:0] w_norm;

    // Priority-encode the highest set bit, then left-justify it to bit 61.
    always_comb begin
        w_msb  = 6'd0;
        for (int i = 0; i < 62; i++) begin
            if (i_mag[i]) begin
                w_msb = 6'(i);
            end else begin
                w_msb = w_msb;
            end
        end
        w_norm = i_mag << (6'd61 - w_msb);
        if (i_mag == 62'd0) begin
            o_fp32 = 32'h0000_0000;
        end else begin
            o_fp32 = {i_sign, fp32_exp_from_msb(w_msb), w_norm[60:38]};
        end
    end

endmodule

// File: rtl/sin_phase_feed.sv
// ----------------------------------------------------------------------------
// sin_phase_feed
//   Phase accumulator front end for the sine unit. Each accepted sample tick
//   captures the current phase, folds it into [-pi/2, +pi/2], scales it to
//   radians and presents it as fp32 together with a one-cycle start pulse.
//   Ports:
//     clk, reset   - clock, synchronous active-high reset
//     sample_tick  - request a sample (accepted only when not busy)
//     freq_inc     - phase increment applied with each accepted tick
//     phase_sync   - clear the phase accumulator
//     theta        - fp32 angle, held until the next result
//     sin_start    - one-cycle pulse marking a new theta
//     busy         - conversion in flight
//     overrun      - sticky: a tick arrived while busy
//     phase        - current accumulator value
// ----------------------------------------------------------------------------
module sin_phase_feed
    import sin_pkg::*;
#(
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_tick,
    input  logic [ACC_W-1:0] freq_inc,
    input  logic             phase_sync,
    output logic [31:0]      theta,
    output logic             sin_start,
    output logic             busy,
    output logic             overrun,
    output logic [ACC_W-1:0] phase
);

    state_t             r_state;
    state_t             w_state_next;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_p;
    logic               r_sign;
    logic [30:0]        r_m;
    logic [61:0]        r_prod;
    logic [31:0]        r_theta;
    logic               r_sin_start;
    logic               r_overrun;

    logic               w_accept;
    logic [31:0]        w_q;
    logic [31:0]        w_abs;
    logic [61:0]        w_prod;
    logic [31:0]        w_fp32;

    assign w_accept = (r_state == ST_IDLE) && sample_tick;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: fixed four-cycle walk once a tick is accepted.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (sample_tick) begin
                    w_state_next = ST_FOLD;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_FOLD: w_state_next = ST_MULT;
            ST_MULT: w_state_next = ST_PACK;
            ST_PACK: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Fold: quadrants 1 and 2 (top bits differ) reflect about pi/2, i.e.
    // q = 2^31 - p; quadrants 0 and 3 are already in range as signed p.
    always_comb begin
        if (r_p[31] ^ r_p[30]) begin
            w_q = 32'h8000_0000 - r_p;
        end else begin
            w_q = r_p;
        end
        if (w_q[31]) begin
            w_abs = 32'd0 - w_q;
        end else begin
            w_abs = w_q;
        end
    end

    // |q| <= 2^30 and K < 2^32, so the product always fits in 62 bits.
    assign w_prod = 62'(r_m) * 62'(PI_Q30);

    ufix62_to_fp32 u_pack (
        .i_sign (r_sign),
        .i_mag  (r_prod),
        .o_fp32 (w_fp32)
    );

    // Datapath: accumulator, pipeline registers, outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc       <= '0;
            r_p         <= '0;
            r_sign      <= 1'b0;
            r_m         <= 31'd0;
            r_prod      <= 62'd0;
            r_theta     <= 32'h0000_0000;
            r_sin_start <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sin_start <= 1'b0;
            if (w_accept) begin
                // A sync with the tick samples phase zero and restarts from it.
                r_p   <= phase_sync ? '0 : r_acc;
                r_acc <= phase_sync ? freq_inc : r_acc + freq_inc;
            end else if (phase_sync) begin
                r_acc <= '0;
            end
            if (sample_tick && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_FOLD: begin
                    r_sign <= w_q[31];
                    r_m    <= w_abs[30:0];
                end
                ST_MULT: begin
                    r_prod <= w_prod;
                end
                ST_PACK: begin
                    r_theta     <= w_fp32;
                    r_sin_start <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign theta     = r_theta;
    assign sin_start = r_sin_start;
    assign busy      = (r_state != ST_IDLE);
    assign overrun   = r_overrun;
    assign phase     = r_acc;

endmodule
